selection_store_bank: RTL and testbench
=======================================

# selection_store_bank

Parametrised successor of the switch-selection storer. It receives framed serial words from the switch-sending side (data line, ctrl flag, 10 MHz sample clock), writes each word into one of DEPTH slots chosen by the queue selector, and honours the safety switch as a write inhibit. On a display trigger it loads the selected slot onto `display_number` for the hex displayer. Everything is resampled into the 50 MHz domain, and frames carry an optional parity bit.

## Interface
Parameters:
- `WIDTH`, 12, stored word width in bits (≥2)
- `DEPTH`, 8, number of slots (2..256)
- `ADDR_W`, 3, queue selector width; must equal ceil(log2(DEPTH))

Ports:
- `fifty_MHz_int_clock`  in  1  sole clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `ten_MHz_synch_input`  in  1  sender's sample clock, async; data valid at its rising edge
- `data_ctrl_input`  in  1  frame flag, async; high for the whole frame
- `serial_input`  in  1  serial data, async, MSB first
- `queue`  in  ADDR_W  slot selector for write and display
- `saftey_switch`  in  1  1 = writes inhibited
- `displaying_trigger_input`  in  1  async; rising edge requests display
- `display_number`  out  WIDTH  registered contents of the last displayed slot
- `slot_written`  out  DEPTH  bit i set once slot i has been written since reset
- `write_done`  out  1  1-cycle pulse: word committed
- `write_rejected`  out  1  1-cycle pulse: complete frame discarded (safety, bad slot, parity)
- `frame_error`  out  1  1-cycle pulse: short frame or overlong frame

## Operation
- All four async inputs pass through 2-flop synchronisers. A third register on the sync clock and on the trigger provides rising-edge detection. Data and ctrl are delayed to match the sync path so they are sampled coherently with the detected edge ("sample event").
- FRAME_LEN = WIDTH (+1 with parity, see Configuration).
- FSM states: IDLE, SHIFT, COMMIT, TAIL.
  - IDLE: a sample event with ctrl=1 shifts in the first bit, latches `queue` into the target register, sets bit count to 1, and moves to SHIFT. A sample event with ctrl=0 is ignored.
  - SHIFT: a sample event with ctrl=1 shifts in a bit and increments the count. When the count reaches FRAME_LEN, go to COMMIT. A sample event with ctrl=0 before that point pulses `frame_error`, discards the frame and returns to IDLE.
  - COMMIT (exactly 1 cycle): if `saftey_switch`=1, or target ≥ DEPTH, or parity fails, pulse `write_rejected` and leave memory untouched. Otherwise write the slot, set its `slot_written` bit and pulse `write_done`. Then go to TAIL.
  - TAIL: wait for a sample event with ctrl=0, then go to IDLE. The first sample event with ctrl=1 here pulses `frame_error` once per frame; the extra bits are ignored.
- Safety is evaluated at COMMIT, not at frame start.
- Display: a trigger rising edge (after sync) loads `mem[queue]` into `display_number` on the next cycle. If queue ≥ DEPTH, 0 is loaded.
- Display in the same cycle as a COMMIT to the same slot returns the pre-write value (read-before-write).
- Pulses are never coincident except `write_done`/`write_rejected` alongside a display load.

## Timing
- Reset values: all outputs 0; all slots 0; FSM IDLE; count 0; synchroniser and edge registers 0.
- Reset mid-frame discards the partial frame; no pulse is emitted.
- Input-to-edge latency: an async rising edge registered at cycle t is acted on at cycle t+3.
- Last-bit sample event at cycle c: COMMIT at c+1. `write_done`/`write_rejected` are visible on the cycle after c+1, and memory reads the new value from c+2.
- Display: trigger sync edge at t+3 gives `display_number` updated at t+4.
- Sync clock high and low phases must each be ≥2 clocks (10 MHz at 50 MHz is supported). Back-to-back frames need ≥1 ctrl-low sample event between them.

## Configuration
- `SEL_STORE_PARITY_EN` defined: each frame carries one extra trailing bit of even parity over the WIDTH data bits. FRAME_LEN = WIDTH+1. A mismatch gives `write_rejected` at COMMIT.
- Not defined: FRAME_LEN = WIDTH, there is no parity logic, and a trailing extra bit counts as overlong (`frame_error`).

## Test plan
- Reset, then send 12'hA5C to queue=3 (safety 0), then display queue=3 -> `write_done` pulse, `display_number`=12'hA5C, `slot_written`=8'h08.
- Send 12'h123 with `saftey_switch`=1 to slot 3 already holding 12'hA5C -> `write_rejected` pulse; display shows 12'hA5C; `slot_written` unchanged.
- Drop ctrl after 7 bits -> `frame_error` pulse, no write. The next full frame of 12'hFFF to slot 0 is stored correctly.
- Send 13 bits with ctrl high (parity disabled), value 12'h0F0 to slot 7 -> `write_done` and one `frame_error`; slot 7 = 12'h0F0.
- With `SEL_STORE_PARITY_EN`, send 12'h001 with parity bit 0 -> `write_rejected`; with parity bit 1 -> `write_done`.
- Assert reset mid-frame after 5 bits, then send 12'h800 to slot 1 -> no pulses during reset; slot 1 = 12'h800; all other slots read 0.

Source files
------------

// File: rtl/selection_store_bank.sv
// selection_store_bank
//
// Receives framed serial words from the switch-sending side and stores each
// word in one of DEPTH slots picked by the queue selector. A display trigger
// copies the selected slot onto display_number. All asynchronous inputs are
// resampled into the 50 MHz domain before use.
//
// Optional feature macro: SEL_STORE_PARITY_EN
//   defined   : each frame carries a trailing even-parity bit (FRAME_LEN = WIDTH+1)
//   undefined : no parity logic, FRAME_LEN = WIDTH
//
// Ports:
//   fifty_MHz_int_clock      in   sole clock, rising edge
//   reset                    in   synchronous, active-high
//   ten_MHz_synch_input      in   sender sample clock (async), data valid at its rise
//   data_ctrl_input          in   frame flag (async), high for the whole frame
//   serial_input             in   serial data (async), MSB first
//   queue [ADDR_W]           in   slot selector for write and display
//   saftey_switch            in   1 = writes inhibited (checked at commit)
//   displaying_trigger_input in   async, rising edge requests a display load
//   display_number [WIDTH]   out  contents of the last displayed slot
//   slot_written [DEPTH]     out  bit i set once slot i has been written
//   write_done               out  1-cycle pulse, word committed
//   write_rejected           out  1-cycle pulse, complete frame discarded
//   frame_error              out  1-cycle pulse, short or overlong frame

module selection_store_bank #(
    parameter int WIDTH  = 12,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              fifty_MHz_int_clock,
    input  logic              reset,
    input  logic              ten_MHz_synch_input,
    input  logic              data_ctrl_input,
    input  logic              serial_input,
    input  logic [ADDR_W-1:0] queue,
    input  logic              saftey_switch,
    input  logic              displaying_trigger_input,
    output logic [WIDTH-1:0]  display_number,
    output logic [DEPTH-1:0]  slot_written,
    output logic              write_done,
    output logic              write_rejected,
    output logic              frame_error
);

`ifdef SEL_STORE_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_TAIL   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers. The sample clock and trigger get a third stage for
    // rising-edge detection; data and ctrl stop at two stages so they are
    // read coherently with the detected sample-clock edge.
    // ------------------------------------------------------------------
    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic ctrl_s1_q, ctrl_s2_q;
    logic data_s1_q, data_s2_q;
    logic trig_s1_q, trig_s2_q, trig_s3_q;

    always_ff @(posedge fifty_MHz_int_clock) begin
        if (reset) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            ctrl_s1_q <= 1'b0;
            ctrl_s2_q <= 1'b0;
            data_s1_q <= 1'b0;
            data_s2_q <= 1'b0;
            trig_s1_q <= 1'b0;
            trig_s2_q <= 1'b0;
            trig_s3_q <= 1'b0;
        end else begin
            sclk_s1_q <= ten_MHz_synch_input;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            ctrl_s1_q <= data_ctrl_input;
            ctrl_s2_q <= ctrl_s1_q;
            data_s1_q <= serial_input;
            data_s2_q <= data_s1_q;
            trig_s1_q <= displaying_trigger_input;
            trig_s2_q <= trig_s1_q;
            trig_s3_q <= trig_s2_q;
        end
    end

    logic sample_evt;
    assign sample_evt = sclk_s2_q & ~sclk_s3_q;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [FRAME_LEN-1:0]   shift_q, shift_d;
    logic [ADDR_W-1:0]      target_q, target_d;
    logic                   tail_err_q, tail_err_d;
    logic                   disp_req_q, disp_req_d;
    logic [WIDTH-1:0]       display_q, display_d;
    logic [DEPTH-1:0]       written_q, written_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       mem_d [DEPTH];
    logic                   write_done_q, write_done_d;
    logic                   write_rejected_q, write_rejected_d;
    logic                   frame_error_q, frame_error_d;
    logic                   mem_we;

    // Frame payload and parity check
    logic [WIDTH-1:0] frame_word;
    logic             parity_ok;
`ifdef SEL_STORE_PARITY_EN
    assign frame_word = shift_q[FRAME_LEN-1:1];
    // Even parity: data bits plus the trailing parity bit XOR to zero.
    assign parity_ok  = ~(^shift_q);
`else
    assign frame_word = shift_q;
    assign parity_ok  = 1'b1;
`endif

    // Selectors may exceed DEPTH when DEPTH is not a power of two.
    logic target_ok, queue_ok;
    assign target_ok = int'(target_q) < DEPTH;
    assign queue_ok  = int'(queue) < DEPTH;

    // ------------------------------------------------------------------
    // Frame receiver FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        count_d          = count_q;
        shift_d          = shift_q;
        target_d         = target_q;
        tail_err_d       = tail_err_q;
        written_d        = written_q;
        mem_we           = 1'b0;
        write_done_d     = 1'b0;
        write_rejected_d = 1'b0;
        frame_error_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sample_evt && ctrl_s2_q) begin
                    shift_d  = {shift_q[FRAME_LEN-2:0], data_s2_q};
                    target_d = queue;
                    count_d  = CNT_W'(1);
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sample_evt) begin
                    if (ctrl_s2_q) begin
                        shift_d = {shift_q[FRAME_LEN-2:0], data_s2_q};
                        count_d = count_q + CNT_W'(1);
                        if (count_q == CNT_W'(FRAME_LEN - 1)) begin
                            state_d = ST_COMMIT;
                        end
                    end else begin
                        // ctrl dropped before the frame was complete
                        frame_error_d = 1'b1;
                        count_d       = '0;
                        state_d       = ST_IDLE;
                    end
                end
            end
            ST_COMMIT: begin
                if (saftey_switch || !target_ok || !parity_ok) begin
                    write_rejected_d = 1'b1;
                end else begin
                    mem_we              = 1'b1;
                    written_d[target_q] = 1'b1;
                    write_done_d        = 1'b1;
                end
                count_d    = '0;
                tail_err_d = 1'b0;
                state_d    = ST_TAIL;
            end
            ST_TAIL: begin
                if (sample_evt) begin
                    if (ctrl_s2_q) begin
                        // Extra bits are dropped; flag overlong once per frame.
                        if (!tail_err_q) begin
                            frame_error_d = 1'b1;
                            tail_err_d    = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Slot memory
    // ------------------------------------------------------------------
    always_comb begin
        mem_d = mem_q;
        if (mem_we) begin
            mem_d[target_q] = frame_word;
        end
    end

    // ------------------------------------------------------------------
    // Display path. The edge is registered once, then the slot is read.
    // mem_q is the pre-write value, so a same-cycle commit is not visible.
    // ------------------------------------------------------------------
    always_comb begin
        disp_req_d = trig_s2_q & ~trig_s3_q;
        display_d  = display_q;
        if (disp_req_q) begin
            display_d = queue_ok ? mem_q[queue] : '0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge fifty_MHz_int_clock) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            count_q          <= '0;
            shift_q          <= '0;
            target_q         <= '0;
            tail_err_q       <= 1'b0;
            disp_req_q       <= 1'b0;
            display_q        <= '0;
            written_q        <= '0;
            write_done_q     <= 1'b0;
            write_rejected_q <= 1'b0;
            frame_error_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q          <= state_d;
            count_q          <= count_d;
            shift_q          <= shift_d;
            target_q         <= target_d;
            tail_err_q       <= tail_err_d;
            disp_req_q       <= disp_req_d;
            display_q        <= display_d;
            written_q        <= written_d;
            write_done_q     <= write_done_d;
            write_rejected_q <= write_rejected_d;
            frame_error_q    <= frame_error_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign display_number = display_q;
    assign slot_written   = written_q;
    assign write_done     = write_done_q;
    assign write_rejected = write_rejected_q;
    assign frame_error    = frame_error_q;

endmodule

// File: tb/tb_selection_store_bank.sv
`timescale 1ns/1ps
module tb_selection_store_bank;

    localparam int WIDTH  = 12;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
`ifdef SEL_STORE_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic              reset;
    logic              sclk;
    logic              sctrl;
    logic              sdata;
    logic [ADDR_W-1:0] queue;
    logic              safety;
    logic              trig;
    logic [WIDTH-1:0]  display_number;
    logic [DEPTH-1:0]  slot_written;
    logic              write_done;
    logic              write_rejected;
    logic              frame_error;

    selection_store_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .fifty_MHz_int_clock      (clk),
        .reset                    (reset),
        .ten_MHz_synch_input      (sclk),
        .data_ctrl_input          (sctrl),
        .serial_input             (sdata),
        .queue                    (queue),
        .saftey_switch            (safety),
        .displaying_trigger_input (trig),
        .display_number           (display_number),
        .slot_written             (slot_written),
        .write_done               (write_done),
        .write_rejected           (write_rejected),
        .frame_error              (frame_error)
    );

    // ---------------- counters / pulse monitor ----------------
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int rej_cnt = 0;
    int ferr_cnt = 0;
    int overlap_cnt = 0;

    always @(negedge clk) begin
        if (write_done)     done_cnt++;
        if (write_rejected) rej_cnt++;
        if (frame_error)    ferr_cnt++;
        if ((write_done && write_rejected) || (frame_error && (write_done || write_rejected)))
            overlap_cnt++;
    end

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] model_mem [DEPTH];
    logic [DEPTH-1:0] model_written;
    logic [WIDTH-1:0] model_disp;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_written = '0;
        model_disp    = '0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b, input logic c);
        @(negedge clk);
        sclk  = 1'b0;
        sdata = b;
        sctrl = c;
        repeat (2) @(negedge clk);
        sclk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Sends nbits with ctrl high (data, then parity if enabled, then random
    // extras), then one ctrl-low event, and checks the outcome against the model.
    task automatic run_frame(input string tag, input logic [WIDTH-1:0] val, input int q,
                             input logic safe, input int nbits, input logic bad_par);
        int d0, r0, f0;
        logic b, bad, exp_done, exp_rej, exp_ferr;
        @(negedge clk);
        queue  = ADDR_W'(q);
        safety = safe;
        d0 = done_cnt; r0 = rej_cnt; f0 = ferr_cnt;
        for (int i = 0; i < nbits; i++) begin
            if (i < WIDTH)          b = val[WIDTH-1-i];
            else if (i < FRAME_LEN) b = (^val) ^ bad_par;
            else                    b = logic'($urandom_range(0, 1));
            send_bit(b, 1'b1);
        end
        send_bit(1'b0, 1'b0);
        repeat (8) @(negedge clk);

        if (nbits < FRAME_LEN) begin
            exp_done = 1'b0; exp_rej = 1'b0; exp_ferr = 1'b1;
        end else begin
            bad = safe;
`ifdef SEL_STORE_PARITY_EN
            bad = bad | bad_par;
`endif
            exp_rej  = bad;
            exp_done = !bad;
            exp_ferr = (nbits > FRAME_LEN);
            if (!bad) begin
                model_mem[q]     = val;
                model_written[q] = 1'b1;
            end
        end
        @(posedge clk);
        check({tag, ":done"},  64'(done_cnt - d0), 64'(exp_done));
        check({tag, ":rej"},   64'(rej_cnt - r0),  64'(exp_rej));
        check({tag, ":ferr"},  64'(ferr_cnt - f0), 64'(exp_ferr));
        check({tag, ":written"}, 64'(slot_written), 64'(model_written));
    endtask

    task automatic display_check(input string tag, input int q, input logic tight);
        logic [WIDTH-1:0] exp;
        exp = model_mem[q];
        @(negedge clk);
        queue = ADDR_W'(q);
        trig  = 1'b1;
        if (tight) begin
            repeat (3) @(negedge clk);
            check({tag, ":early"}, 64'(display_number), 64'(model_disp));
            @(negedge clk);
        end else begin
            repeat (5) @(negedge clk);
        end
        check({tag, ":value"}, 64'(display_number), 64'(exp));
        model_disp = exp;
        trig = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; sclk = 1'b0; sctrl = 1'b0; sdata = 1'b0; trig = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int d0, r0, f0;
        int q, nb;
        logic [WIDTH-1:0] v;
        logic s, bp;

        reset = 1'b1; sclk = 1'b0; sctrl = 1'b0; sdata = 1'b0;
        queue = '0; safety = 1'b0; trig = 1'b0;
        apply_reset();
        check("rst:display", 64'(display_number), 64'(0));
        check("rst:written", 64'(slot_written), 64'(0));
        check("rst:pulses",  64'(done_cnt + rej_cnt + ferr_cnt), 64'(0));

        // Store and display A5C in slot 3 (exact display latency checked)
        run_frame("a5c", 12'hA5C, 3, 1'b0, FRAME_LEN, 1'b0);
        display_check("disp3", 3, 1'b1);
        check("sw08", 64'(slot_written), 64'h08);

        // Safety inhibits the write
        run_frame("safe", 12'h123, 3, 1'b1, FRAME_LEN, 1'b0);
        display_check("disp3_safe", 3, 1'b0);

        // Short frame then a good frame to slot 0
        run_frame("short7", 12'h5A5, 2, 1'b0, 7, 1'b0);
        run_frame("fff", 12'hFFF, 0, 1'b0, FRAME_LEN, 1'b0);
        display_check("disp0", 0, 1'b0);
        display_check("disp2", 2, 1'b0);

        // Overlong frame still stores the word, one frame_error
        run_frame("long", 12'h0F0, 7, 1'b0, FRAME_LEN + 1, 1'b0);
        display_check("disp7", 7, 1'b0);

`ifdef SEL_STORE_PARITY_EN
        run_frame("par_bad",  12'h001, 4, 1'b0, FRAME_LEN, 1'b1);
        display_check("disp4_bad", 4, 1'b0);
        run_frame("par_good", 12'h001, 4, 1'b0, FRAME_LEN, 1'b0);
        display_check("disp4_good", 4, 1'b0);
`endif

        // Reset in the middle of a frame
        @(negedge clk);
        queue = 3'd5; safety = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(logic'(i[0]), 1'b1);
        d0 = done_cnt; r0 = rej_cnt; f0 = ferr_cnt;
        apply_reset();
        check("midrst:pulses", 64'((done_cnt - d0) + (rej_cnt - r0) + (ferr_cnt - f0)), 64'(0));
        check("midrst:written", 64'(slot_written), 64'(0));
        check("midrst:display", 64'(display_number), 64'(0));
        run_frame("x800", 12'h800, 1, 1'b0, FRAME_LEN, 1'b0);
        for (int i = 0; i < DEPTH; i++) display_check($sformatf("post_rst_slot%0d", i), i, 1'b0);

        // Randomised frames
        for (int n = 0; n < 16; n++) begin
            q  = $urandom_range(0, DEPTH - 1);
            v  = WIDTH'($urandom);
            s  = ($urandom_range(0, 3) == 0);
            bp = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0:       nb = $urandom_range(1, FRAME_LEN - 1);
                1:       nb = FRAME_LEN + $urandom_range(1, 3);
                default: nb = FRAME_LEN;
            endcase
            run_frame($sformatf("rnd%0d", n), v, q, s, nb, bp);
            display_check($sformatf("rnd%0d_disp", n), $urandom_range(0, DEPTH - 1), 1'b0);
        end

        check("no_overlap", 64'(overlap_cnt), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
